vram_stream_reader: RTL and testbench

// Bus master for the 32KB byte-wide video RAM: streams a run of bytes out of VRAM into a

---
 rtl/vram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_vram_stream_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_stream_reader.sv
// VRAM bus master: streams a run of bytes from video RAM into a small FWFT FIFO for the
// pixel pipeline, and shares the single RAM port with a CPU byte-write port.
module vram_stream_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] start_addr,
  input  logic [15:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e        state_q, state_d;
  logic [14:0]   ptr_q, ptr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          inflight_q;
  logic          done_q, done_d;
  logic [14:0]   addr_hold_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          issue, push, pop, flush;

  assign pop   = (count_q != '0) && pix_ready;
  assign push  = inflight_q && !flush;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StFetch;
            ptr_d       = start_addr;
            remaining_d = length;
          end
        end
      end
      StFetch: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = StIdle;
        // Credit counts the byte still in flight so the FIFO can never overflow.
        end else if (!wr_req && ((count_q + CW'(inflight_q)) < DepthC)) begin
          issue       = 1'b1;
          ptr_d       = ptr_q + 15'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (!inflight_q && (count_q == '0)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);
  end

  // CPU writes always own the port; the address is otherwise held when no read issues.
  always_comb begin
    if (wr_req)     mem_addr = wr_addr;
    else if (issue) mem_addr = ptr_q;
    else            mem_addr = addr_hold_q;
  end

  assign wr_ack    = wr_req && rst_n;
  assign mem_we    = wr_ack;
  assign mem_wdata = wr_data;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign pix_valid = (count_q != '0);
  assign pix_data  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      addr_hold_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
      done_q      <= done_d;
      addr_hold_q <= mem_addr;
      count_q     <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= mem_rdata;
          wr_ptr_q         <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_stream_reader.sv
// Directed self-checking bench for vram_stream_reader with a behavioural synchronous VRAM.
module tb_vram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;

  vram_stream_reader #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide VRAM: read data valid the cycle after the address.
  logic [7:0] ram [32768];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Monitor: popped bytes, read addresses (a new address on a non-write busy cycle), pulses.
  logic [7:0]  popped [$];
  logic [14:0] rd_addr [$];
  int          rd_cyc [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  logic [14:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (pix_valid && pix_ready) popped.push_back(pix_data);
      if (busy && !mem_we && (mem_addr !== prev_addr)) begin
        rd_addr.push_back(mem_addr);
        rd_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
    prev_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic run(input logic [14:0] a, input logic [15:0] len);
    start      = 1'b1;
    start_addr = a;
    length     = len;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int p0, input logic [7:0] first, input int n);
    logic [7:0] e;
    check({tag, "_byte_count"}, 32'(popped.size() - p0), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = first + 8'(i);
      if (p0 + i < popped.size()) check($sformatf("%s_byte%0d", tag, i), 32'(popped[p0 + i]), 32'(e));
    end
  endtask

  task automatic check_addrs(input string tag, input int r0, input logic [14:0] first, input int n);
    logic [14:0] e;
    check({tag, "_read_count"}, 32'(rd_addr.size() - r0), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = first + 15'(i);
      if (r0 + i < rd_addr.size()) check($sformatf("%s_addr%0d", tag, i), 32'(rd_addr[r0 + i]), 32'(e));
    end
  endtask

  initial begin
    int d0, p0, r0, b0, n;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    pix_ready = 1'b1; wr_req = 1'b1; wr_addr = 15'h1234; wr_data = 8'h77;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    #9 rst_n = 1'b1;
    tick(); tick();

    for (int i = 0; i < 4; i++) cpu_write(15'h0010 + 15'(i), 8'hA0 + 8'(i));
    cpu_write(15'h7FFE, 8'hB0);
    cpu_write(15'h7FFF, 8'hB1);
    cpu_write(15'h0000, 8'hB2);
    for (int i = 0; i < 8; i++) cpu_write(15'h0020 + 15'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 8; i++) cpu_write(15'h0040 + 15'(i), 8'hD0 + 8'(i));
    for (int i = 0; i < 8; i++) cpu_write(15'h0050 + 15'(i), 8'hE0 + 8'(i));
    tick();

    // 1: basic four-byte run
    d0 = done_cnt; p0 = popped.size(); r0 = rd_addr.size();
    run(15'h0010, 16'd4);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", d0);
    repeat (3) tick();
    check_addrs("t1", r0, 15'h0010, 4);
    if (rd_cyc.size() >= r0 + 4) check("t1_back_to_back", 32'(rd_cyc[r0 + 3] - rd_cyc[r0]), 32'd3);
    check_bytes("t1", p0, 8'hA0, 4);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: address wrap
    d0 = done_cnt; p0 = popped.size(); r0 = rd_addr.size();
    run(15'h7FFE, 16'd3);
    wait_done("t2", d0);
    repeat (3) tick();
    check_addrs("t2", r0, 15'h7FFE, 3);
    check_bytes("t2", p0, 8'hB0, 3);

    // 3: back-pressure stalls fetch at FIFO depth
    d0 = done_cnt; p0 = popped.size(); r0 = rd_addr.size();
    pix_ready = 1'b0;
    run(15'h0020, 16'd8);
    repeat (10) tick();
    check("t3_stall_reads", 32'(rd_addr.size() - r0), 32'd4);
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_valid", 32'(pix_valid), 32'd1);
    check("t3_stall_head", 32'(pix_data), 32'hC0);
    pix_ready = 1'b1;
    wait_done("t3", d0);
    repeat (3) tick();
    check_addrs("t3", r0, 15'h0020, 8);
    check_bytes("t3", p0, 8'hC0, 8);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // 4: CPU write mid-fetch preempts one read
    d0 = done_cnt; p0 = popped.size(); r0 = rd_addr.size();
    run(15'h0040, 16'd8);
    tick();
    wr_req = 1'b1; wr_addr = 15'h0100; wr_data = 8'h5A;
    #1;
    check("t4_wr_ack", 32'(wr_ack), 32'd1);
    check("t4_mem_we", 32'(mem_we), 32'd1);
    check("t4_mem_addr", 32'(mem_addr), 32'h0100);
    check("t4_mem_wdata", 32'(mem_wdata), 32'h5A);
    tick();
    wr_req = 1'b0;
    #1;
    check("t4_we_low", 32'(mem_we), 32'd0);
    wait_done("t4", d0);
    repeat (3) tick();
    check_addrs("t4", r0, 15'h0040, 8);
    check_bytes("t4", p0, 8'hD0, 8);
    d0 = done_cnt; p0 = popped.size();
    run(15'h0100, 16'd1);
    wait_done("t4rd", d0);
    repeat (2) tick();
    check_bytes("t4rd", p0, 8'h5A, 1);

    // 5: zero-length run
    d0 = done_cnt; r0 = rd_addr.size(); b0 = busy_cyc;
    run(15'h0030, 16'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    check("t5_done_low", 32'(done), 32'd0);
    tick();
    check("t5_done_once", 32'(done_cnt - d0), 32'd1);
    check("t5_no_busy", 32'(busy_cyc - b0), 32'd0);
    check("t5_no_reads", 32'(rd_addr.size() - r0), 32'd0);

    // 6: abort mid-run, then a fresh run
    d0 = done_cnt; p0 = popped.size();
    run(15'h0050, 16'd8);
    n = 0;
    while ((popped.size() - p0) < 2 && n < 100) begin
      tick();
      n++;
    end
    check("t6_two_popped", 32'((popped.size() - p0) >= 2), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_valid_flushed", 32'(pix_valid), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    repeat (5) tick();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_still_empty", 32'(pix_valid), 32'd0);

    d0 = done_cnt; p0 = popped.size(); r0 = rd_addr.size();
    run(15'h0010, 16'd4);
    wait_done("t6new", d0);
    repeat (3) tick();
    check_bytes("t6new", p0, 8'hA0, 4);
    check("t6new_done_once", 32'(done_cnt - d0), 32'd1);

    // abort beats start in IDLE
    d0 = done_cnt; r0 = rd_addr.size();
    start = 1'b1; abort = 1'b1; start_addr = 15'h0060; length = 16'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("abort_start_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_start_no_reads", 32'(rd_addr.size() - r0), 32'd0);

    // reset mid-fetch
    d0 = done_cnt;
    pix_ready = 1'b0;
    run(15'h0020, 16'd8);
    repeat (3) tick();
    check("t7_pre_busy", 32'(busy), 32'd1);
    check("t7_pre_valid", 32'(pix_valid), 32'd1);
    wr_req = 1'b1; wr_addr = 15'h0200; wr_data = 8'h11;
    rst_n = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_valid", 32'(pix_valid), 32'd0);
    check("t7_pix_data", 32'(pix_data), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_mem_we", 32'(mem_we), 32'd0);
    check("t7_wr_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    #3 rst_n = 1'b1;
    pix_ready = 1'b1;
    repeat (3) tick();
    check("t7_after_busy", 32'(busy), 32'd0);
    check("t7_no_done", 32'(done_cnt - d0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
